// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: LFSR mole selection, per-mole timeout, per-button
// lockout after wrong presses, round timer and a high score held across rounds.
module whack_game_core #(
    parameter int N_MOLES      = 8,
    parameter int SCORE_W      = 8,
    parameter int MOLE_CYCLES  = 500000,
    parameter int LOCK_CYCLES  = 1000000,
    parameter int ROUND_CYCLES = 15000000,
    localparam int IDX_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_MOLES-1:0] btn,
    input  logic [1:0]         mode,
    output logic [IDX_W-1:0]   mole_idx,
    output logic               mole_valid,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [N_MOLES-1:0] lockout
);
    localparam int MC_W = $clog2(MOLE_CYCLES + 1);
    localparam int RC_W = $clog2(ROUND_CYCLES + 1);
    localparam int LC_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SAT = '1;

    // IDLE wait for start | ARM pick next mole | UP mole visible | OVER round finished
    typedef enum logic [1:0] {IDLE, ARM, UP, OVER} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic               start_q;
    logic [N_MOLES-1:0] btn_q;
    logic [1:0]         mode_q;
    logic [MC_W-1:0]    mole_cnt;
    logic [MC_W-1:0]    mole_t;
    logic [RC_W-1:0]    round_cnt;
    logic [LC_W-1:0]    lock_cnt [N_MOLES];
    logic [LC_W-1:0]    lock_nxt [N_MOLES];
    logic               start_rise, hit, round_end, expire, enter_over;
    logic [N_MOLES-1:0] press, wrong, mole_sel;
    logic [IDX_W-1:0]   folded, pick;

    assign start_rise = start & ~start_q;
    assign press      = btn & ~btn_q & ~lockout;
    assign mole_sel   = N_MOLES'(1) << mole_idx;
    assign hit        = |(press & mole_sel);
    assign wrong      = press & ~mole_sel;
    assign round_end  = (round_cnt == RC_W'(1));
    assign expire     = (mode_q != 2'd3) && (mole_cnt == MC_W'(1));
    assign enter_over = !start_rise && round_end && ((state == ARM) || (state == UP));
    assign mole_valid = (state == UP);
    assign game_over  = (state == OVER);

    // Fold raw LFSR bits into range, then step past the previous mole
    always_comb begin
        folded = lfsr[IDX_W-1:0];
        if (int'(folded) >= N_MOLES) folded = IDX_W'(int'(folded) - N_MOLES);
        pick = folded;
        if (folded == mole_idx) pick = (int'(folded) == N_MOLES - 1) ? '0 : folded + IDX_W'(1);
    end

    always_comb begin
        case (mode)
            2'd0:    mole_t = MC_W'(MOLE_CYCLES);
            2'd1:    mole_t = MC_W'(MOLE_CYCLES >> 1);
            2'd2:    mole_t = MC_W'(MOLE_CYCLES >> 2);
            default: mole_t = mole_cnt;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_MOLES; i++) begin
            lock_nxt[i] = (lock_cnt[i] != '0) ? lock_cnt[i] - LC_W'(1) : '0;
            if ((state == UP) && wrong[i]) lock_nxt[i] = LC_W'(LOCK_CYCLES);
            if (start_rise) lock_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= 16'hACE1;
            start_q    <= 1'b0;
            btn_q      <= '0;
            mode_q     <= '0;
            mole_idx   <= '0;
            mole_cnt   <= '0;
            round_cnt  <= '0;
            score      <= '0;
            misses     <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            lockout    <= '0;
            for (int i = 0; i < N_MOLES; i++) lock_cnt[i] <= '0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            start_q <= start;
            btn_q   <= btn;
            for (int i = 0; i < N_MOLES; i++) begin
                lock_cnt[i] <= lock_nxt[i];
                lockout[i]  <= (lock_nxt[i] != '0);
            end
            new_high <= 1'b0;
            if (enter_over && (score > high_score)) begin
                high_score <= score;
                new_high   <= 1'b1;
            end
            if (start_rise) begin
                state     <= ARM;
                score     <= '0;
                misses    <= '0;
                round_cnt <= RC_W'(ROUND_CYCLES);
            end else begin
                case (state)
                    ARM: begin
                        mole_idx  <= pick;
                        mode_q    <= mode;
                        mole_cnt  <= mole_t;
                        round_cnt <= round_cnt - RC_W'(1);
                        state     <= round_end ? OVER : UP;
                    end
                    UP: begin
                        round_cnt <= round_cnt - RC_W'(1);
                        if (mode_q != 2'd3) mole_cnt <= mole_cnt - MC_W'(1);
                        if (round_end) begin
                            state <= OVER;
                        end else if (hit) begin
                            score <= (score == SAT) ? score : score + SCORE_W'(1);
                            state <= ARM;
                        end else if (expire) begin
                            misses <= (misses == SAT) ? misses : misses + SCORE_W'(1);
                            state  <= ARM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_whack_game_core.sv
// Bench for whack_game_core: event-level reference model feeds a scoreboard
// queue that a separate monitor drains, plus directed corner-case checks.
module tb_whack_game_core;
    localparam int N  = 5;
    localparam int SW = 4;
    localparam int MC = 8;
    localparam int LC = 10;
    localparam int RC = 100;
    localparam int IW = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  btn = '0;
    logic [1:0]    mode = '0;
    logic [IW-1:0] mole_idx;
    logic          mole_valid, game_over, new_high;
    logic [SW-1:0] score, misses, high_score;
    logic [N-1:0]  lockout;

    whack_game_core #(
        .N_MOLES(N), .SCORE_W(SW), .MOLE_CYCLES(MC), .LOCK_CYCLES(LC), .ROUND_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn), .mode(mode),
        .mole_idx(mole_idx), .mole_valid(mole_valid), .game_over(game_over),
        .score(score), .misses(misses), .high_score(high_score),
        .new_high(new_high), .lockout(lockout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          mv;
        logic          go;
        logic [SW-1:0] sc;
        logic [SW-1:0] mi;
        logic [SW-1:0] hs;
        logic          nh;
        logic [N-1:0]  lk;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: phase plus absolute cycle stamps for round, mole and locks
    int        m_phase;   // 0 idle, 1 arm, 2 up, 3 over
    int        m_cyc, m_round_t0, m_mole_t0, m_life, m_mode;
    int        m_idx, m_score, m_miss, m_high, m_nh;
    int        m_lock_end [N];
    bit [15:0] m_lfsr;
    bit        m_pstart;
    bit [N-1:0] m_pbtn;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, int'({mole_idx, mole_valid, game_over, score, misses, high_score, new_high, lockout}), 0);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cyc = 0; m_round_t0 = 0; m_mole_t0 = 0; m_life = MC; m_mode = 0;
        m_idx = 0; m_score = 0; m_miss = 0; m_high = 0; m_nh = 0;
        for (int i = 0; i < N; i++) m_lock_end[i] = 0;
        m_lfsr = 16'hACE1; m_pstart = 1'b0; m_pbtn = '0;
    endtask

    function automatic int m_pick();
        int r;
        r = int'(m_lfsr[IW-1:0]);
        if (r >= N) r = r - N;
        if (r == m_idx) r = (r + 1) % N;
        return r;
    endfunction

    task automatic m_enter_over();
        m_phase = 3;
        if (m_score > m_high) begin
            m_high = m_score;
            m_nh = 1;
        end
    endtask

    task automatic model_step(input bit s, input logic [N-1:0] b, input logic [1:0] md);
        bit         srise;
        bit [N-1:0] pr;
        int         last;
        srise = s && !m_pstart;
        for (int i = 0; i < N; i++) pr[i] = b[i] && !m_pbtn[i] && !(m_cyc < m_lock_end[i]);
        last = m_round_t0 + RC - 1;
        m_nh = 0;
        if (srise) begin
            m_phase = 1; m_score = 0; m_miss = 0; m_round_t0 = m_cyc + 1;
            for (int i = 0; i < N; i++) m_lock_end[i] = 0;
        end else if (m_phase == 1) begin
            m_idx = m_pick();
            m_mode = int'(md);
            m_mole_t0 = m_cyc + 1;
            if (md != 2'd3) m_life = MC >> md;
            if (m_cyc == last) m_enter_over();
            else m_phase = 2;
        end else if (m_phase == 2) begin
            for (int i = 0; i < N; i++) if (pr[i] && i != m_idx) m_lock_end[i] = m_cyc + 1 + LC;
            if (m_cyc == last) m_enter_over();
            else if (pr[m_idx]) begin
                m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
                m_phase = 1;
            end else if (m_mode != 3 && m_cyc == m_mole_t0 + m_life - 1) begin
                m_miss = (m_miss < SMAX) ? m_miss + 1 : SMAX;
                m_phase = 1;
            end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_pstart = s;
        m_pbtn = b;
        m_cyc++;
    endtask

    function automatic snap_t model_snap();
        snap_t e;
        e.idx = IW'(m_idx);
        e.mv  = (m_phase == 2);
        e.go  = (m_phase == 3);
        e.sc  = SW'(m_score);
        e.mi  = SW'(m_miss);
        e.hs  = SW'(m_high);
        e.nh  = (m_nh != 0);
        for (int i = 0; i < N; i++) e.lk[i] = (m_cyc < m_lock_end[i]);
        return e;
    endfunction

    // Drive one cycle of inputs, predict the post-edge outputs, then advance
    task automatic step(input bit s, input logic [N-1:0] b, input logic [1:0] md);
        start = s;
        btn   = b;
        mode  = md;
        model_step(s, b, md);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #2;
    endtask

    snap_t mon_a, mon_e;
    int    mon_cyc = 0;
    int    mole_count = 0;
    int    last_idx = 0;
    bit    have_prev = 1'b0;
    bit    prev_mv = 1'b0;

    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {mole_idx, mole_valid, game_over, score, misses, high_score, new_high, lockout};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got idx=%0d mv=%0b go=%0b score=%0d misses=%0d high=%0d nh=%0b lock=%b expected idx=%0d mv=%0b go=%0b score=%0d misses=%0d high=%0d nh=%0b lock=%b",
                         mon_cyc, mon_a.idx, mon_a.mv, mon_a.go, mon_a.sc, mon_a.mi, mon_a.hs, mon_a.nh, mon_a.lk,
                         mon_e.idx, mon_e.mv, mon_e.go, mon_e.sc, mon_e.mi, mon_e.hs, mon_e.nh, mon_e.lk);
            end
        end
        if (rst) begin
            have_prev = 1'b0;
            prev_mv = 1'b0;
        end else begin
            if (mole_valid && !prev_mv) begin
                mole_count++;
                checks++;
                if (int'(mole_idx) >= N || (have_prev && int'(mole_idx) == last_idx)) begin
                    errors++;
                    $display("FAIL mole_pick: got idx %0d previous %0d (must be <%0d and differ)", mole_idx, last_idx, N);
                end
                have_prev = 1'b1;
                last_idx = int'(mole_idx);
            end
            prev_mv = mole_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] b;
        logic [1:0]   md;
        int first_mv, first_go, nh_count, up_cycles, lk_cnt, w, c, delay, sc0, r;
        bit first, hitnow;

        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_outputs");
        rst = 1'b0;
        model_reset();
        repeat (3) step(1'b0, '0, 2'd0);

        // Mode 0, no presses: mole life, misses and round length
        step(1'b1, '0, 2'd0);
        first_mv = -1; first_go = -1;
        for (int k = 1; k <= 110; k++) begin
            if (mole_valid && first_mv < 0) first_mv = k;
            if (game_over && first_go < 0) first_go = k;
            step(1'b0, '0, 2'd0);
        end
        chk("first_mole_latency", first_mv, 2);
        chk("round_length", first_go, RC + 1);
        chk("misses_no_press", int'(misses), 11);

        // Hit every mole; the first one exactly on its expiry cycle
        step(1'b1, '0, 2'd0);
        first = 1'b1; nh_count = 0; delay = MC - 1;
        for (int k = 0; k < 120; k++) begin
            if (new_high) begin
                nh_count++;
                chk("new_high_value", int'(high_score), SMAX);
                chk("new_high_with_over", int'(game_over), 1);
            end
            b = '0;
            if (m_phase == 1) delay = first ? MC - 1 : int'($urandom_range(0, 3));
            hitnow = 1'b0;
            if (m_phase == 2 && (m_cyc - m_mole_t0) == delay) begin
                b[m_idx] = 1'b1;
                hitnow = first;
            end
            step(1'b0, b, 2'd0);
            if (hitnow) begin
                chk("expiry_hit_score", int'(score), 1);
                chk("expiry_hit_misses", int'(misses), 0);
                first = 1'b0;
            end
        end
        chk("new_high_pulses", nh_count, 1);
        chk("high_after_saturation", int'(high_score), SMAX);
        chk("misses_all_hit", int'(misses), 0);

        // Mode 3: untimed mole, correct hit on the final round cycle
        step(1'b1, '0, 2'd3);
        up_cycles = 0; nh_count = 0;
        for (int k = 1; k <= 105; k++) begin
            if (mole_valid) up_cycles++;
            if (new_high) nh_count++;
            b = '0;
            if (m_phase == 2 && m_cyc == m_round_t0 + RC - 1) b[m_idx] = 1'b1;
            step(1'b0, b, 2'd3);
        end
        chk("untimed_mole_up", up_cycles, RC - 1);
        chk("final_cycle_hit_score", int'(score), 0);
        chk("lower_round_no_new_high", nh_count, 0);
        chk("high_kept", int'(high_score), SMAX);

        // Wrong press lockout, held correct button, then mid-round restart
        step(1'b1, '0, 2'd0);
        for (int k = 0; k < 20 && m_phase != 2; k++) step(1'b0, '0, 2'd0);
        w = (m_idx + 1) % N;
        b = '0; b[w] = 1'b1;
        step(1'b0, b, 2'd0);
        lk_cnt = 0;
        for (int j = 1; j <= 14; j++) begin
            if (lockout[w]) lk_cnt++;
            b = '0;
            if (j <= 9 && (j % 2) == 1) b[w] = 1'b1;
            step(1'b0, b, 2'd0);
        end
        chk("lockout_length", lk_cnt, LC);
        for (int k = 0; k < 20 && m_phase != 2; k++) step(1'b0, '0, 2'd0);
        c = m_idx;
        sc0 = m_score;
        b = '0; b[c] = 1'b1;
        repeat (12) step(1'b0, b, 2'd0);
        chk("held_button_single_score", int'(score), sc0 + 1);
        chk("held_button_no_lock", int'(lockout[c]), 0);
        repeat (2) step(1'b0, '0, 2'd0);
        repeat (10) step(1'b0, N'($urandom & $urandom), 2'd0);
        step(1'b1, '0, 2'd0);
        chk("restart_score", int'(score), 0);
        chk("restart_misses", int'(misses), 0);
        chk("restart_lockout", int'(lockout), 0);
        first_go = -1;
        for (int k = 1; k <= 110; k++) begin
            if (game_over && first_go < 0) first_go = k;
            step(1'b0, '0, 2'd0);
        end
        chk("restart_round_length", first_go, RC + 1);

        // Randomised rounds until enough moles have been seen
        r = 0;
        while (mole_count < 220 && r < 20) begin
            md = (r % 2 == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            step(1'b1, '0, md);
            for (int k = 0; k < 104; k++) begin
                b = N'($urandom & $urandom & $urandom);
                if (m_phase == 2 && $urandom_range(0, 3) == 0) b[m_idx] = 1'b1;
                step(1'b0, b, md);
            end
            r++;
        end

        // Asynchronous reset in the middle of a scoring round
        step(1'b1, '0, 2'd0);
        b = '0;
        for (int k = 0; k < 20; k++) begin
            if (m_phase == 2 && b == '0) begin
                b = '0;
                b[m_idx] = 1'b1;
            end else begin
                b = '0;
            end
            step(1'b0, b, 2'd0);
        end
        btn = '0;
        rst = 1'b1;
        #1;
        check_zero("async_reset_mid_round");
        @(posedge clk);
        #2;
        check_zero("reset_held");
        rst = 1'b0;
        model_reset();
        repeat (5) step(1'b0, '0, 2'd0);

        #20;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/whack_game_core.md
# whack_game_core

Parametrised game engine for the whack-a-mole design, the successor to the fixed 8-button, untimed-mole controller. It takes debounced start and button levels, picks moles from an internal LFSR, and times each mole out so unhit moles count as misses. It applies a lockout per button, runs the round timer, and holds a high score across rounds. It sits between the per-button debouncers and the 7-segment/score output logic.

## Interface
- N_MOLES, 8: mole/button count, 2..16; IDX_W = max(1, clog2(N_MOLES)).
- SCORE_W, 8: width of score, misses and high_score.
- MOLE_CYCLES, 500000: base mole visible time in cycles, ≥4.
- LOCK_CYCLES, 1000000: lockout time after a wrong press, ≥1.
- ROUND_CYCLES, 15000000: play cycles per round, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  debounced start level.
- btn  in  N_MOLES  debounced button levels.
- mode  in  2  difficulty, sampled in ARM.
- mole_idx  out  IDX_W  current mole index.
- mole_valid  out  1  mole is up (state UP).
- game_over  out  1  state OVER.
- score  out  SCORE_W  hits this round.
- misses  out  SCORE_W  expired moles this round.
- high_score  out  SCORE_W  best score since reset.
- new_high  out  1  one-cycle pulse when high_score increases.
- lockout  out  N_MOLES  bit i set while button i is locked.

## Operation
- Reset: state IDLE; all outputs 0; LFSR = 16'hACE1; start_q and btn_q = 0.
- Edge detection:
  - start_rise = start & ~start_q.
  - press = btn & ~btn_q & ~lockout, so only rising edges count.
  - Held buttons never re-trigger.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in all states.
  - raw = lfsr[IDX_W-1:0]; if raw ≥ N_MOLES, use raw − N_MOLES.
  - If the result equals the previous mole_idx, use (result+1) mod N_MOLES.
- States IDLE, ARM, UP, OVER.
- start_rise in any state has the highest priority:
  - clears score, misses and all lockout counters;
  - loads round_cnt = ROUND_CYCLES;
  - next state ARM.
- ARM (1 cycle):
  - mole_idx ← pick.
  - mole_cnt ← T, where mode 0: MOLE_CYCLES, 1: MOLE_CYCLES>>1, 2: MOLE_CYCLES>>2, 3: untimed (mole_cnt frozen).
  - round_cnt decrements.
  - Next state UP, or OVER if round_cnt==1.
- UP: round_cnt and mole_cnt (modes 0–2) decrement each cycle. Priority, highest first:
  - (a) round_cnt==1 → OVER; a press on that cycle is not scored.
  - (b) press[mole_idx] → score+1, saturating → ARM.
  - (c) mole_cnt==1, modes 0–2 → misses+1, saturating → ARM.
- Wrong press: any press bit ≠ mole_idx, in UP only, including the cycle of a hit.
  - Loads that bit's lock counter with LOCK_CYCLES.
  - A locked bit's press is masked and does not reload the counter.
- Lock counters decrement every cycle in every state; lockout[i] = counter nonzero.
- OVER:
  - mole_valid=0 and game_over=1.
  - Presses are ignored.
  - If score > high_score: high_score ← score and new_high pulses for one cycle (first OVER cycle).
  - Only start_rise leaves OVER.
- IDLE: waits for start_rise.
- high_score is cleared only by rst.

## Timing
- Every output is registered except mole_valid and game_over, which are decoded from the state register.
- Round length: ARM+UP cycles from start_rise to OVER = ROUND_CYCLES exactly.
  - game_over asserts ROUND_CYCLES+1 cycles after the edge that sampled start_rise.
- Mole life: mole_valid stays high for exactly T cycles if not hit.
  - The miss increment is visible the cycle after the last UP cycle.
- Hit at UP cycle t:
  - score updated and mole_valid=0 at t+1 (ARM);
  - new mole_idx and mole_valid=1 at t+2.
- A hit and an expiry in the same cycle count as a hit.
- A round end and a hit in the same cycle count as a round end.
- A wrong press at cycle t: lockout bit high from t+1 for LOCK_CYCLES cycles.
- new_high: single cycle, coincident with the first game_over cycle.
- rst mid-round: immediate return to reset values, including high_score.

## Test plan
All scenarios use N_MOLES=5, SCORE_W=4, MOLE_CYCLES=8, LOCK_CYCLES=10, ROUND_CYCLES=100.

- Reset, then start pulse:
  - all outputs 0 during reset;
  - mole_valid rises 2 cycles after the start edge;
  - mole_idx < 5 and never repeats consecutively over 200 moles.
- Mode 0, no presses:
  - each mole stays up 8 cycles;
  - misses increments per mole;
  - game_over asserts exactly 101 cycles after start is sampled.
- Press btn[mole_idx] every mole:
  - score counts up and saturates at 15;
  - misses stays 0;
  - new_high pulses once with high_score=15 at game_over.
- Wrong button pressed:
  - lockout bit high 10 cycles;
  - repeated presses of it are ignored;
  - holding the correct button does not score the next mole.
- Corner cases:
  - hit on the expiry cycle → score+1, misses unchanged;
  - hit on the final round cycle → no score;
  - mode 3 → mole never expires;
  - mode 2 → mole up 2 cycles.
- Restarts:
  - start re-pressed mid-round → score, misses and lockout clear and the round timer restarts;
  - second round with lower score → high_score unchanged, no new_high;
  - rst → high_score=0.
